// File: rtl/of_pkg.sv
// Shared constants and types for the operand fetch block.
// Index space: GPRs occupy 0..NUM_REGS-1, the private register sits at PRIV_IDX.
package of_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int PEND_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PRIV_IDX = NUM_REGS;
  localparam int IDX_W    = ADDR_W + 1;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef logic [PEND_W-1:0]       pend_cnt_t;
  typedef pend_cnt_t [NUM_REGS:0]  pend_vec_t;

  function automatic logic [IDX_W-1:0] reg_idx(input logic priv, input logic [ADDR_W-1:0] addr);
    return priv ? IDX_W'(PRIV_IDX) : {1'b0, addr};
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Per-register pending-write counters with busy/full flags for decode hazards.
// Optional macro WB_BYPASS_EN: a source with one pending write retiring this cycle is not busy.
module of_scoreboard
  import of_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] src1_idx_i,
  input  logic             src1_use_i,
  input  logic [IDX_W-1:0] src2_idx_i,
  input  logic             src2_use_i,
  input  logic             issue_i,
  input  logic             dst_write_i,
  input  logic [IDX_W-1:0] dst_idx_i,
  input  logic             wb_write_i,
  input  logic [IDX_W-1:0] wb_idx_i,
  output logic             src1_busy_o,
  output logic             src2_busy_o,
  output logic             dst_full_o
);

  pend_vec_t         cnt_q, cnt_d;
  logic [NUM_REGS:0] inc_v, dec_v;

  always_comb begin
    src1_busy_o = src1_use_i && (cnt_q[src1_idx_i] != '0);
    src2_busy_o = src2_use_i && (cnt_q[src2_idx_i] != '0);
`ifdef WB_BYPASS_EN
    if (wb_write_i && (wb_idx_i == src1_idx_i) && (cnt_q[src1_idx_i] == PEND_W'(1)))
      src1_busy_o = 1'b0;
    if (wb_write_i && (wb_idx_i == src2_idx_i) && (cnt_q[src2_idx_i] == PEND_W'(1)))
      src2_busy_o = 1'b0;
`endif
    dst_full_o = (cnt_q[dst_idx_i] == PEND_MAX);
  end

  // Simultaneous issue and retire to one register cancel; retire at zero is ignored.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    cnt_d = cnt_q;
    for (int i = 0; i <= NUM_REGS; i++) begin
      inc_v[i] = issue_i && dst_write_i && (dst_idx_i == IDX_W'(i));
      dec_v[i] = wb_write_i && (wb_idx_i == IDX_W'(i));
      if (inc_v[i] && !dec_v[i])
        cnt_d[i] = cnt_q[i] + PEND_W'(1);
      else if (!inc_v[i] && dec_v[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage register file reader with writeback port and pending-write stall.
// Optional macro WB_BYPASS_EN: forward wb_data to a source retiring in the same cycle.
module operand_fetch
  import of_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_reg_write_i,
  input  logic              wb_dst_or_private_i,
  input  logic [ADDR_W-1:0] wb_dst_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_src1_addr_i,
  input  logic [ADDR_W-1:0] id_src2_addr_i,
  input  logic              id_src1_use_i,
  input  logic              id_src2_use_i,
  input  logic              id_src2_private_i,
  input  logic              id_reg_write_i,
  input  logic              id_dst_private_i,
  input  logic [ADDR_W-1:0] id_dst_addr_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_src1_data_o,
  output logic [DATA_W-1:0] ex_src2_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS+1];
  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_src1_q, ex_src2_q;
  logic [DATA_W-1:0] op1_d, op2_d;

  logic [IDX_W-1:0] src1_idx, src2_idx, dst_idx, wb_idx;
  logic             src1_busy, src2_busy, dst_full, issue;

  assign src1_idx = reg_idx(1'b0, id_src1_addr_i);
  assign src2_idx = reg_idx(id_src2_private_i, id_src2_addr_i);
  assign dst_idx  = reg_idx(id_dst_private_i, id_dst_addr_i);
  assign wb_idx   = reg_idx(wb_dst_or_private_i, wb_dst_addr_i);

  of_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src1_idx_i  (src1_idx),
    .src1_use_i  (id_src1_use_i),
    .src2_idx_i  (src2_idx),
    .src2_use_i  (id_src2_use_i),
    .issue_i     (issue),
    .dst_write_i (id_reg_write_i),
    .dst_idx_i   (dst_idx),
    .wb_write_i  (wb_reg_write_i),
    .wb_idx_i    (wb_idx),
    .src1_busy_o (src1_busy),
    .src2_busy_o (src2_busy),
    .dst_full_o  (dst_full)
  );

  assign stall_o = id_valid_i && (src1_busy || src2_busy || (id_reg_write_i && dst_full));
  assign issue   = id_valid_i && !stall_o;

  // Unused sources present zero so EX never sees stale register contents.
  always_comb begin
    op1_d = '0;
    op2_d = '0;
    if (id_src1_use_i) op1_d = regs_q[src1_idx];
    if (id_src2_use_i) op2_d = regs_q[src2_idx];
`ifdef WB_BYPASS_EN
    if (id_src1_use_i && wb_reg_write_i && (wb_idx == src1_idx)) op1_d = wb_data_i;
    if (id_src2_use_i && wb_reg_write_i && (wb_idx == src2_idx)) op2_d = wb_data_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_reg_write_i) begin
      regs_q[wb_idx] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_src1_q  <= '0;
      ex_src2_q  <= '0;
    end else begin
      ex_valid_q <= issue;
      if (issue) begin
        ex_src1_q <= op1_d;
        ex_src2_q <= op2_d;
      end
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_src1_data_o = ex_src1_q;
  assign ex_src2_data_o = ex_src2_q;

endmodule
